// File: rtl/tap_dl_pkg.sv
// ============================================================================
// Module : tap_dl_pkg
// Brief  : Shared width derivations and FSM encoding for the tap delay line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tap_dl_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } tap_state_e;

   function automatic int calc_ch_w(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

   function automatic int calc_idx_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int calc_nbeat(input int depth, input int sym);
      return (sym != 0) ? (depth + 1) / 2 : depth;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tap_dl_bank.sv
// ============================================================================
// Module : tap_dl_bank
// Brief  : One channel circular sample buffer with two combinational read ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tap_dl_bank #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 33,
   parameter int IDX_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [IDX_W-1:0] rd_addr_a_i,
   input  logic [IDX_W-1:0] rd_addr_b_i,
   output logic [WIDTH-1:0] rd_data_a_o,
   output logic [WIDTH-1:0] rd_data_b_o,
   output logic [IDX_W-1:0] wptr_o,
   output logic             primed_o
);

   localparam int              FILL_W     = $clog2(DEPTH + 1);
   localparam logic [FILL_W-1:0] C_FULL   = FILL_W'(DEPTH);
   localparam logic [IDX_W-1:0]  C_LAST   = IDX_W'(DEPTH - 1);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [IDX_W-1:0]  wptr_q;
   logic [FILL_W-1:0] fill_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         fill_q <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         fill_q <= '0;
      end else if (wr_en_i) begin
         mem_q[wptr_q] <= wr_data_i;
         wptr_q        <= (wptr_q == C_LAST) ? '0 : wptr_q + 1'b1;
         if (fill_q != C_FULL) fill_q <= fill_q + 1'b1;
      end
   end

   assign rd_data_a_o = (rd_addr_a_i <= C_LAST) ? mem_q[rd_addr_a_i] : '0;
   assign rd_data_b_o = (rd_addr_b_i <= C_LAST) ? mem_q[rd_addr_b_i] : '0;
   assign wptr_o      = wptr_q;
   assign primed_o    = (fill_q == C_FULL);

endmodule

`default_nettype wire

// File: rtl/tap_delay_line_mc.sv
// ============================================================================
// Module : tap_delay_line_mc
// Brief  : Multi-channel FIR tap delay line streaming taps to a shared MAC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tap_delay_line_mc import tap_dl_pkg::*; #(
   parameter int WIDTH  = 3,
   parameter int DEPTH  = 33,
   parameter int NUM_CH = 2,
   parameter int SYM    = 1,
   localparam int CH_W  = calc_ch_w(NUM_CH),
   localparam int IDX_W = calc_idx_w(DEPTH)
) (
   input  logic              iClk12M,
   input  logic              iRst,
   input  logic              iFlush,
   input  logic              iInValid,
   input  logic [CH_W-1:0]   iInCh,
   input  logic [WIDTH-1:0]  iInData,
   output logic              oInReady,
   input  logic              iRdStart,
   input  logic [CH_W-1:0]   iRdCh,
   output logic              oBusy,
   output logic              oTapValid,
   input  logic              iTapReady,
   output logic [WIDTH-1:0]  oTapA,
   output logic [WIDTH-1:0]  oTapB,
   output logic [IDX_W-1:0]  oTapIdx,
   output logic              oTapLast,
   output logic              oTapMid,
   output logic [NUM_CH-1:0] oPrimed
);

   localparam int               NBEAT       = calc_nbeat(DEPTH, SYM);
   localparam logic [IDX_W:0]   C_DEPTH     = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   C_DEPTH_M1  = (IDX_W+1)'(DEPTH - 1);
   localparam logic [IDX_W-1:0] C_LAST_PTR  = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] C_LAST_BEAT = IDX_W'(NBEAT - 1);
   localparam logic [CH_W:0]    C_NUM_CH    = (CH_W+1)'(NUM_CH);
   localparam logic             C_MID_EN    = (SYM != 0) && ((DEPTH % 2) == 1);

   tap_state_e       state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [IDX_W-1:0] base_q, base_d, k_q, k_d;
   logic [WIDTH-1:0] tap_a_q, tap_a_d, tap_b_q, tap_b_d;
   logic             last_q, last_d, mid_q, mid_d;

   logic [WIDTH-1:0] w_bank_a    [NUM_CH];
   logic [WIDTH-1:0] w_bank_b    [NUM_CH];
   logic [IDX_W-1:0] w_bank_wptr [NUM_CH];
   logic [NUM_CH-1:0] w_primed;

   logic w_busy, w_in_ch_ok, w_rd_ch_ok, w_wr_ok, w_start, w_hs, w_same_wr, w_beat_mid;
   logic [CH_W-1:0]  w_sel_ch;
   logic [IDX_W-1:0] w_wp, w_snap, w_rd_base, w_rd_k, w_addr_a, w_addr_b;
   logic [IDX_W:0]   w_sum_a, w_sum_b, w_mod_a, w_mod_b;
   logic [WIDTH-1:0] w_rd_a, w_rd_b, w_beat_a, w_beat_b;

   assign w_busy     = (state_q == ST_STREAM);
   assign w_in_ch_ok = ({1'b0, iInCh} < C_NUM_CH);
   assign w_rd_ch_ok = ({1'b0, iRdCh} < C_NUM_CH);
   assign oInReady   = !(w_busy && (iInCh == ch_q));
   assign w_wr_ok    = iInValid && oInReady && w_in_ch_ok && !iFlush;
   assign w_start    = !iFlush && !w_busy && iRdStart && w_rd_ch_ok;
   assign w_hs       = w_busy && iTapReady;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
      tap_dl_bank #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .IDX_W (IDX_W)
      ) u_bank (
         .clk_i       (iClk12M),
         .rst_i       (iRst),
         .flush_i     (iFlush),
         .wr_en_i     (w_wr_ok && (iInCh == CH_W'(g))),
         .wr_data_i   (iInData),
         .rd_addr_a_i (w_addr_a),
         .rd_addr_b_i (w_addr_b),
         .rd_data_a_o (w_bank_a[g]),
         .rd_data_b_o (w_bank_b[g]),
         .wptr_o      (w_bank_wptr[g]),
         .primed_o    (w_primed[g])
      );
   end

   // Start snapshot counts a same-cycle write to the started channel, whose
   // data is bypassed into beat 0 because the bank has not stored it yet.
   always_comb begin
      w_same_wr = w_wr_ok && (iInCh == iRdCh);
      w_wp      = w_bank_wptr[iRdCh];
      w_snap    = w_same_wr ? ((w_wp == C_LAST_PTR) ? '0 : w_wp + 1'b1) : w_wp;
      w_sel_ch  = w_busy ? ch_q : iRdCh;
      w_rd_base = w_busy ? base_q : w_snap;
      w_rd_k    = w_busy ? k_q + 1'b1 : '0;
      w_sum_a   = {1'b0, w_rd_base} + C_DEPTH_M1 - {1'b0, w_rd_k};
      w_sum_b   = {1'b0, w_rd_base} + {1'b0, w_rd_k};
      w_mod_a   = (w_sum_a >= C_DEPTH) ? w_sum_a - C_DEPTH : w_sum_a;
      w_mod_b   = (w_sum_b >= C_DEPTH) ? w_sum_b - C_DEPTH : w_sum_b;
      w_addr_a  = w_mod_a[IDX_W-1:0];
      w_addr_b  = w_mod_b[IDX_W-1:0];
      w_rd_a    = w_bank_a[w_sel_ch];
      w_rd_b    = w_bank_b[w_sel_ch];
      w_beat_mid = C_MID_EN && (w_rd_k == C_LAST_BEAT);
      w_beat_a  = (!w_busy && w_same_wr) ? iInData : w_rd_a;
      w_beat_b  = ((SYM != 0) && !w_beat_mid) ? w_rd_b : '0;
   end

   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         base_q  <= '0;
         k_q     <= '0;
         tap_a_q <= '0;
         tap_b_q <= '0;
         last_q  <= 1'b0;
         mid_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         base_q  <= base_d;
         k_q     <= k_d;
         tap_a_q <= tap_a_d;
         tap_b_q <= tap_b_d;
         last_q  <= last_d;
         mid_q   <= mid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (iFlush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (w_start) state_d = ST_STREAM;
            ST_STREAM: if (w_hs && last_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ch_d    = ch_q;
      base_d  = base_q;
      k_d     = k_q;
      tap_a_d = tap_a_q;
      tap_b_d = tap_b_q;
      last_d  = last_q;
      mid_d   = mid_q;
      if (iFlush || (w_hs && last_q)) begin
         k_d     = '0;
         tap_a_d = '0;
         tap_b_d = '0;
         last_d  = 1'b0;
         mid_d   = 1'b0;
      end else if (w_start || w_hs) begin
         if (w_start) begin
            ch_d   = iRdCh;
            base_d = w_snap;
         end
         k_d     = w_rd_k;
         tap_a_d = w_beat_a;
         tap_b_d = w_beat_b;
         last_d  = (w_rd_k == C_LAST_BEAT);
         mid_d   = w_beat_mid;
      end
   end

   always_comb begin
      oBusy     = w_busy;
      oTapValid = w_busy;
      oTapA     = tap_a_q;
      oTapB     = tap_b_q;
      oTapIdx   = k_q;
      oTapLast  = last_q;
      oTapMid   = mid_q;
      oPrimed   = w_primed;
   end

endmodule

`default_nettype wire

// File: tb/tb_tap_delay_line_mc.sv
// ============================================================================
// Module : tb_tap_delay_line_mc
// Brief  : Directed bench driving a single-tap and a symmetric-pair instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tap_delay_line_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0, in_valid = 1'b0, rd_start = 1'b0, tap_ready = 1'b0;
   logic [0:0] in_ch = '0, rd_ch = '0;
   logic [7:0] in_data = '0;

   logic       rdy0, busy0, valid0, last0, mid0;
   logic [7:0] a0, b0;
   logic [5:0] idx0;
   logic [1:0] primed0;
   logic       rdy1, busy1, valid1, last1, mid1;
   logic [7:0] a1, b1;
   logic [5:0] idx1;
   logic [1:0] primed1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tap_delay_line_mc #(.WIDTH(8), .DEPTH(33), .NUM_CH(2), .SYM(0)) u_dut0 (
      .iClk12M(clk), .iRst(rst), .iFlush(flush), .iInValid(in_valid), .iInCh(in_ch),
      .iInData(in_data), .oInReady(rdy0), .iRdStart(rd_start), .iRdCh(rd_ch),
      .oBusy(busy0), .oTapValid(valid0), .iTapReady(tap_ready), .oTapA(a0), .oTapB(b0),
      .oTapIdx(idx0), .oTapLast(last0), .oTapMid(mid0), .oPrimed(primed0));

   tap_delay_line_mc #(.WIDTH(8), .DEPTH(33), .NUM_CH(2), .SYM(1)) u_dut1 (
      .iClk12M(clk), .iRst(rst), .iFlush(flush), .iInValid(in_valid), .iInCh(in_ch),
      .iInData(in_data), .oInReady(rdy1), .iRdStart(rd_start), .iRdCh(rd_ch),
      .oBusy(busy1), .oTapValid(valid1), .iTapReady(tap_ready), .oTapA(a1), .oTapB(b1),
      .oTapIdx(idx1), .oTapLast(last1), .oTapMid(mid1), .oPrimed(primed1));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [0:0] ch, input logic [7:0] d);
      in_valid = 1'b1; in_ch = ch; in_data = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic start(input logic [0:0] ch);
      rd_start = 1'b1; rd_ch = ch;
      tick();
      rd_start = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy0, valid0, last0, mid0, a0, b0, idx0, primed0, rdy0} !== {4'b0, 8'd0, 8'd0, 6'd0, 2'b00, 1'b1}) begin
         failures++;
         $display("FAIL reset_sym0: got %h expected %h",
                  {busy0, valid0, last0, mid0, a0, b0, idx0, primed0, rdy0}, {4'b0, 8'd0, 8'd0, 6'd0, 2'b00, 1'b1});
      end
      checks++;
      if ({busy1, valid1, last1, mid1, a1, b1, idx1, primed1, rdy1} !== {4'b0, 8'd0, 8'd0, 6'd0, 2'b00, 1'b1}) begin
         failures++;
         $display("FAIL reset_sym1: got %h expected %h",
                  {busy1, valid1, last1, mid1, a1, b1, idx1, primed1, rdy1}, {4'b0, 8'd0, 8'd0, 6'd0, 2'b00, 1'b1});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_readout();
      logic [15:0] got0, exp0;
      logic [23:0] got1, exp1;
      do_flush();
      for (int i = 1; i <= 33; i++) wr(1'b0, 8'(i));
      checks++;
      if (primed0 !== 2'b01) begin
         failures++;
         $display("FAIL basic_primed: got %b expected 01", primed0);
      end
      tap_ready = 1'b1;
      start(1'b0);
      for (int k = 0; k < 33; k++) begin
         got0 = {valid0, a0, idx0, last0};
         exp0 = {1'b1, 8'(33 - k), 6'(k), (k == 32)};
         checks++;
         if (got0 !== exp0) begin
            failures++;
            $display("FAIL basic_sym0_beat%0d: got %h expected %h", k, got0, exp0);
         end
         if (k < 17) begin
            got1 = {valid1, a1, b1, idx1, last1};
            exp1 = {1'b1, 8'(33 - k), (k == 16) ? 8'd0 : 8'(k + 1), 6'(k), (k == 16)};
            checks++;
            if (got1 !== exp1 || mid1 !== (k == 16)) begin
               failures++;
               $display("FAIL basic_sym1_beat%0d: got %h mid %b expected %h mid %b", k, got1, mid1, exp1, (k == 16));
            end
         end else begin
            checks++;
            if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
               failures++;
               $display("FAIL basic_sym1_idle%0d: got valid %b busy %b expected 0 0", k, valid1, busy1);
            end
         end
         tick();
      end
      checks++;
      if ({valid0, busy0, last0} !== 3'b000) begin
         failures++;
         $display("FAIL basic_end: got %b expected 000", {valid0, busy0, last0});
      end
      tap_ready = 1'b0;
   endtask

   task automatic test_wrap();
      do_flush();
      for (int i = 1; i <= 40; i++) wr(1'b1, 8'(i));
      for (int i = 1; i <= 10; i++) wr(1'b0, 8'(i));
      checks++;
      if (primed0 !== 2'b10) begin
         failures++;
         $display("FAIL wrap_primed: got %b expected 10", primed0);
      end
      tap_ready = 1'b1;
      start(1'b1);
      for (int k = 0; k < 33; k++) begin
         checks++;
         if ({valid0, a0, idx0} !== {1'b1, 8'(40 - k), 6'(k)}) begin
            failures++;
            $display("FAIL wrap_ch1_beat%0d: got a=%0d idx=%0d expected a=%0d idx=%0d", k, a0, idx0, 40 - k, k);
         end
         tick();
      end
      start(1'b0);
      for (int k = 0; k < 33; k++) begin
         checks++;
         if ({valid0, a0, idx0} !== {1'b1, (k < 10) ? 8'(10 - k) : 8'd0, 6'(k)}) begin
            failures++;
            $display("FAIL wrap_ch0_beat%0d: got a=%0d idx=%0d expected a=%0d", k, a0, idx0, (k < 10) ? 10 - k : 0);
         end
         tick();
      end
      checks++;
      if (valid0 !== 1'b0) begin
         failures++;
         $display("FAIL wrap_end: got valid %b expected 0", valid0);
      end
      tap_ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      logic [3:0] pat;
      logic [7:0] last_ch1;
      logic       rdy;
      int         k, cyc;
      pat = 4'b1001; k = 0; cyc = 0; last_ch1 = '0;
      do_flush();
      for (int i = 1; i <= 33; i++) wr(1'b0, 8'(i));
      tap_ready = 1'b0;
      start(1'b0);
      while (k < 33 && cyc < 200) begin
         checks++;
         if ({valid0, a0, idx0} !== {1'b1, 8'(33 - k), 6'(k)}) begin
            failures++;
            $display("FAIL bp_beat%0d_cyc%0d: got a=%0d idx=%0d expected a=%0d idx=%0d", k, cyc, a0, idx0, 33 - k, k);
         end
         rdy = pat[cyc % 4];
         tap_ready = rdy;
         in_valid = 1'b1; in_ch = cyc[0]; in_data = 8'(100 + cyc);
         #1;
         checks++;
         if (rdy0 !== cyc[0]) begin
            failures++;
            $display("FAIL bp_inready_cyc%0d: got %b expected %b", cyc, rdy0, cyc[0]);
         end
         if (cyc[0]) last_ch1 = in_data;
         @(posedge clk); #1;
         if (rdy) k++;
         cyc++;
      end
      in_valid = 1'b0; tap_ready = 1'b0; in_ch = 1'b0;
      checks++;
      if (cyc >= 200) begin
         failures++;
         $display("FAIL bp_timeout: got %0d beats expected 33", k);
      end
      #1;
      checks++;
      if ({valid0, busy0, rdy0} !== 3'b001) begin
         failures++;
         $display("FAIL bp_end: got %b expected 001", {valid0, busy0, rdy0});
      end
      tick();
      start(1'b1);
      checks++;
      if ({valid0, a0, idx0} !== {1'b1, last_ch1, 6'd0}) begin
         failures++;
         $display("FAIL bp_ch1_written: got a=%0d expected a=%0d", a0, last_ch1);
      end
      do_flush();
   endtask

   task automatic test_same_cycle_start();
      int n;
      do_flush();
      wr(1'b0, 8'd5);
      wr(1'b0, 8'd6);
      tap_ready = 1'b0;
      in_valid = 1'b1; in_ch = 1'b0; in_data = 8'd99; rd_start = 1'b1; rd_ch = 1'b0;
      tick();
      in_valid = 1'b0; rd_start = 1'b0;
      checks++;
      if ({valid0, a0, idx0} !== {1'b1, 8'd99, 6'd0}) begin
         failures++;
         $display("FAIL same_cycle_beat0: got a=%0d idx=%0d expected a=99 idx=0", a0, idx0);
      end
      rd_start = 1'b1; rd_ch = 1'b1;
      tick();
      rd_start = 1'b0; rd_ch = 1'b0;
      checks++;
      if ({valid0, a0, idx0} !== {1'b1, 8'd99, 6'd0}) begin
         failures++;
         $display("FAIL busy_start_hold: got a=%0d idx=%0d expected a=99 idx=0", a0, idx0);
      end
      tap_ready = 1'b1;
      n = 0;
      while (valid0 && n < 100) begin
         if (n == 1 && a0 !== 8'd6) begin
            failures++;
            $display("FAIL same_cycle_beat1: got %0d expected 6", a0);
         end
         if (n == 2 && a0 !== 8'd5) begin
            failures++;
            $display("FAIL same_cycle_beat2: got %0d expected 5", a0);
         end
         if (n == 1 || n == 2) checks++;
         n++;
         tick();
      end
      checks++;
      if (n !== 33) begin
         failures++;
         $display("FAIL busy_start_count: got %0d beats expected 33", n);
      end
      tick();
      checks++;
      if (valid0 !== 1'b0) begin
         failures++;
         $display("FAIL busy_start_restart: got valid %b expected 0", valid0);
      end
      tap_ready = 1'b0;
   endtask

   task automatic test_abort();
      do_flush();
      for (int i = 1; i <= 33; i++) wr(1'b0, 8'(i));
      tap_ready = 1'b1;
      start(1'b0);
      repeat (5) tick();
      checks++;
      if ({idx0, a0} !== {6'd5, 8'd28}) begin
         failures++;
         $display("FAIL flush_pre_beat5: got idx=%0d a=%0d expected idx=5 a=28", idx0, a0);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if ({valid0, busy0, last0, primed0} !== 5'b0) begin
         failures++;
         $display("FAIL flush_abort: got %b expected 00000", {valid0, busy0, last0, primed0});
      end
      start(1'b0);
      for (int k = 0; k < 33; k++) begin
         checks++;
         if ({valid0, a0, idx0} !== {1'b1, 8'd0, 6'(k)}) begin
            failures++;
            $display("FAIL flush_zero_beat%0d: got v=%b a=%0d idx=%0d expected v=1 a=0 idx=%0d", k, valid0, a0, idx0, k);
         end
         tick();
      end
      for (int i = 1; i <= 33; i++) wr(1'b0, 8'(i));
      start(1'b0);
      repeat (5) tick();
      checks++;
      if ({idx0, a0} !== {6'd5, 8'd28}) begin
         failures++;
         $display("FAIL rst_pre_beat5: got idx=%0d a=%0d expected idx=5 a=28", idx0, a0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({valid0, busy0, last0, primed0, a0, idx0} !== 19'b0) begin
         failures++;
         $display("FAIL rst_abort: got %h expected 0", {valid0, busy0, last0, primed0, a0, idx0});
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({valid0, busy0, primed0} !== 4'b0) begin
         failures++;
         $display("FAIL rst_after: got %b expected 0000", {valid0, busy0, primed0});
      end
      start(1'b0);
      for (int k = 0; k < 33; k++) begin
         checks++;
         if ({valid0, a0, idx0} !== {1'b1, 8'd0, 6'(k)}) begin
            failures++;
            $display("FAIL rst_zero_beat%0d: got v=%b a=%0d idx=%0d expected v=1 a=0 idx=%0d", k, valid0, a0, idx0, k);
         end
         tick();
      end
      tap_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_readout();
      test_wrap();
      test_back_pressure();
      test_same_cycle_start();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tap_delay_line_mc.md
Name: tap_delay_line_mc

Overview:
Parametrised multi-channel FIR tap delay line. It replaces the fixed 33-output shift chain with per-channel circular buffers. Taps are streamed serially (one or two per beat) to a time-multiplexed MAC running at iClk12M, with a ready/valid handshake. It sits between the sample front-end (600 kHz strobe per channel) and the shared MAC/coefficient sequencer.

Parameters:
WIDTH, 3, sample bit width (data is opaque; no arithmetic on it)
DEPTH, 33, taps per channel (>=2)
NUM_CH, 2, independent channels (>=1)
SYM, 1, 1 = symmetric pair readout for linear-phase FIR; 0 = single-tap readout
Derived: CH_W = max(1,clog2(NUM_CH)); IDX_W = max(1,clog2(DEPTH)); NBEAT = SYM ? ceil(DEPTH/2) : DEPTH

Ports:
iClk12M  in  1  system clock
iRst  in  1  asynchronous reset, active-high
iFlush  in  1  synchronous clear of all channels; aborts any readout
iInValid  in  1  sample write request
iInCh  in  CH_W  write channel
iInData  in  WIDTH  sample
oInReady  out  1  write accepted this cycle when high
iRdStart  in  1  readout request
iRdCh  in  CH_W  readout channel
oBusy  out  1  readout in progress
oTapValid  out  1  tap beat valid
iTapReady  in  1  MAC accepts beat
oTapA  out  WIDTH  tap k (newest side)
oTapB  out  WIDTH  tap DEPTH-1-k (SYM=1 only; 0 otherwise)
oTapIdx  out  IDX_W  beat index k
oTapLast  out  1  final beat of readout
oTapMid  out  1  SYM=1, odd DEPTH, centre beat (oTapB forced 0)
oPrimed  out  NUM_CH  channel has received >=DEPTH samples since reset/flush

Behaviour:
- Reset (iRst high, async): all storage, write pointers and fill counters = 0; oBusy, oTapValid, oTapLast, oTapMid = 0; oTapA, oTapB, oTapIdx = 0; oPrimed = 0. oInReady is combinational and = 1 after reset.
- Storage: per channel DEPTH x WIDTH registers plus wptr[ch] (0..DEPTH-1).
- Write: accepted when iInValid & oInReady & iInCh<NUM_CH. Stores at wptr[ch], then wptr wraps DEPTH-1 -> 0. Fill counter saturates at DEPTH; oPrimed[ch] = (fill==DEPTH).
- Out-of-range iInCh or iRdCh: request ignored, no state change.
- Tap addressing: tap k = sample written k writes ago (k=0 newest) = mem[(wptr-1-k) mod DEPTH]. Unwritten slots read 0.
- oInReady = !(oBusy && iInCh==active read channel). Writes to other channels proceed during readout.
- FSM states: IDLE, STREAM.
  - IDLE: iRdStart & valid channel -> latch channel and snapshot wptr, go to STREAM. oBusy=1 from the next cycle.
  - Snapshot: includes a same-cycle write to the same channel, so the new sample becomes tap 0.
  - iRdStart while oBusy=1 is ignored.
- STREAM:
  - First beat is registered: oTapValid=1 the cycle after start acceptance, k=0.
  - A beat holds stable while oTapValid & !iTapReady.
  - On handshake, k increments and the next beat is presented the following cycle, giving 1 beat/cycle under continuous ready.
  - SYM=0: oTapA = tap k, k = 0..DEPTH-1.
  - SYM=1: oTapA = tap k, oTapB = tap DEPTH-1-k, k = 0..NBEAT-1. If DEPTH is odd, the last beat has oTapMid=1 and oTapB=0.
  - oTapLast=1 on beat NBEAT-1. After its handshake, the next cycle has oTapValid=0 and oBusy=0 (state IDLE), and a new start may be accepted that cycle.
- iFlush (priority over all other inputs):
  - Clears storage, wptr, fill and oPrimed.
  - Forces IDLE; oTapValid, oTapLast and oBusy drop the next cycle.
  - A simultaneous write or start is discarded.
- iRst mid-readout: immediate return to reset values; no partial beat is emitted.

Decomposition:
- Shared package tap_dl_pkg: CH_W/IDX_W/NBEAT derivation functions and the FSM state encoding (ST_IDLE, ST_STREAM).
- One sub-module, tap_dl_bank: single-channel circular buffer with wptr, fill counter and two combinational read ports (addr A, addr B). It is instantiated NUM_CH times.
- The top level holds the FSM, channel mux and output registers.

Test Plan:
1. WIDTH=8, DEPTH=33, SYM=0. Reset, write ch0 samples 1..33, start ch0 with iTapReady=1 -> 33 consecutive beats oTapA=33,32..1, oTapIdx 0..32, oTapLast only at idx 32, oPrimed=2'b01.
2. Same fill, SYM=1 -> 17 beats: beat0 A=33 B=1; beat15 A=18 B=16; beat16 A=17 B=0 with oTapMid=1 and oTapLast=1.
3. Wrap-around: write 40 samples (1..40) to ch1, start ch1 -> taps 40 down to 8. Only 10 samples to ch0 -> ch0 taps 10..1 then 23 zeros, and oPrimed[0]=0.
4. Back-pressure: toggle iTapReady 1,0,0,1 during streaming -> beat values and oTapIdx held while ready is low, no beat lost or repeated. Concurrent writes to ch1 while reading ch0 are accepted; writes to ch0 see oInReady=0 until oBusy falls.
5. Same-cycle write 99 and start on idle ch0 -> first beat oTapA=99. iRdStart while busy is ignored (beat count unchanged).
6. iFlush at beat 5, then separately iRst at beat 5 -> next cycle oTapValid=0, oBusy=0, oPrimed=0. A subsequent readout returns all zeros.
